// File: rtl/hazard_control_unit_if.sv
// Hazard-unit bus: ID-stage operand/control fields in, forwarding/stall/flush controls out.
interface hazard_control_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0]       ID_RA;
  logic [3:0]       ID_RB;
  logic [3:0]       ID_RD;
  logic             use_RA;
  logic             use_RB;
  logic             use_RD;
  logic             ID_RF_enable;
  logic             ID_load_instr;
  logic             branch_taken;
  logic [1:0]       fwd_A;
  logic [1:0]       fwd_B;
  logic [1:0]       fwd_D;
  logic             PC_LE;
  logic             IF_ID_LE;
  logic             NOP_sel;
  logic             IF_ID_Clr;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // Pipeline side: presents the ID instruction, consumes the hazard controls.
  modport master (
    output ID_RA, ID_RB, ID_RD, use_RA, use_RB, use_RD, ID_RF_enable, ID_load_instr,
           branch_taken,
    input  fwd_A, fwd_B, fwd_D, PC_LE, IF_ID_LE, NOP_sel, IF_ID_Clr, stall_count, flush_count
  );

  modport slave (
    input  ID_RA, ID_RB, ID_RD, use_RA, use_RB, use_RD, ID_RF_enable, ID_load_instr,
           branch_taken,
    output fwd_A, fwd_B, fwd_D, PC_LE, IF_ID_LE, NOP_sel, IF_ID_Clr, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_control_unit.sv
// 5-stage pipeline hazard controller: shadow EX/MEM/WB destinations drive forwarding selects,
// a one-cycle load-use stall, taken-branch IF/ID flush and saturating debug counters.
module hazard_control_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 Clk,
  input  logic                 Clr,
  hazard_control_unit_if.slave bus
);

  logic [3:0]       ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  logic             ex_we_q, ex_we_d, mem_we_q, mem_we_d, wb_we_q, wb_we_d;
  logic             ex_ld_q, ex_ld_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             hit_a, hit_b, hit_d, stall, flush;

  // A used, non-PC source that names the destination of a load still in EX.
  function automatic logic ld_hit(input logic use_x, input logic [3:0] src,
                                  input logic [3:0] rd, input logic we, input logic ld);
    return use_x && (src != 4'hF) && we && ld && (rd == src);
  endfunction

  // Youngest producer wins; an EX load cannot supply data yet, so it is skipped.
  function automatic logic [1:0] fwd_sel(input logic use_x, input logic [3:0] src,
                                         input logic [3:0] e_rd, input logic e_we,
                                         input logic e_ld, input logic [3:0] m_rd,
                                         input logic m_we, input logic [3:0] w_rd,
                                         input logic w_we);
    if (!use_x || src == 4'hF)            return 2'b00;
    if (e_we && e_rd == src && !e_ld)     return 2'b01;
    if (m_we && m_rd == src)              return 2'b10;
    if (w_we && w_rd == src)              return 2'b11;
    return 2'b00;
  endfunction

  always_comb begin
    hit_a = ld_hit(bus.use_RA, bus.ID_RA, ex_rd_q, ex_we_q, ex_ld_q);
    hit_b = ld_hit(bus.use_RB, bus.ID_RB, ex_rd_q, ex_we_q, ex_ld_q);
    hit_d = ld_hit(bus.use_RD, bus.ID_RD, ex_rd_q, ex_we_q, ex_ld_q);
    stall = hit_a | hit_b | hit_d;
    flush = bus.branch_taken & ~stall;
  end

  always_comb begin
    ex_rd_d  = stall ? 4'h0 : bus.ID_RD;
    ex_we_d  = stall ? 1'b0 : bus.ID_RF_enable;
    ex_ld_d  = stall ? 1'b0 : bus.ID_load_instr;
    mem_rd_d = ex_rd_q;
    mem_we_d = ex_we_q;
    wb_rd_d  = mem_rd_q;
    wb_we_d  = mem_we_q;

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      ex_rd_q     <= 4'h0;
      ex_we_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      mem_rd_q    <= 4'h0;
      mem_we_q    <= 1'b0;
      wb_rd_q     <= 4'h0;
      wb_we_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_rd_q     <= ex_rd_d;
      ex_we_q     <= ex_we_d;
      ex_ld_q     <= ex_ld_d;
      mem_rd_q    <= mem_rd_d;
      mem_we_q    <= mem_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_we_q     <= wb_we_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.fwd_A       = fwd_sel(bus.use_RA, bus.ID_RA, ex_rd_q, ex_we_q, ex_ld_q,
                                   mem_rd_q, mem_we_q, wb_rd_q, wb_we_q);
  assign bus.fwd_B       = fwd_sel(bus.use_RB, bus.ID_RB, ex_rd_q, ex_we_q, ex_ld_q,
                                   mem_rd_q, mem_we_q, wb_rd_q, wb_we_q);
  assign bus.fwd_D       = fwd_sel(bus.use_RD, bus.ID_RD, ex_rd_q, ex_we_q, ex_ld_q,
                                   mem_rd_q, mem_we_q, wb_rd_q, wb_we_q);
  assign bus.PC_LE       = ~stall;
  assign bus.IF_ID_LE    = ~stall;
  assign bus.NOP_sel     = stall;
  assign bus.IF_ID_Clr   = flush;
  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed vector table, counter saturation,
// mid-run clear, then randomized traffic against an in-flight instruction queue model.
module tb_hazard_control_unit;
  localparam int unsigned CNT_W = 16;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic Clk;
  logic Clr;
  int   checks = 0;
  int   errors = 0;

  hazard_control_unit_if #(.CNT_W(CNT_W)) bus ();

  hazard_control_unit #(.CNT_W(CNT_W)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit       clr, chk, chkf;
    bit [3:0] ra, rb, rd;
    bit       ua, ub, ud, we, ld, br;
    bit [1:0] fa, fb, fd;
    bit       pc, nop, fclr;
    int       sc, fc;
  } vec_t;

  typedef struct {
    bit [3:0] rd;
    bit       we;
    bit       ld;
  } inst_t;

  vec_t  tbl[23];
  inst_t pipe[$];       // [0]=EX, [1]=MEM, [2]=WB
  int    m_sc, m_fc;

  function automatic vec_t v(bit clr, bit chk, bit chkf, bit [3:0] ra, bit [3:0] rb,
                             bit [3:0] rd, bit ua, bit ub, bit ud, bit we, bit ld, bit br,
                             bit [1:0] fa, bit [1:0] fb, bit [1:0] fd, bit pc, bit nop,
                             bit fclr, int sc, int fc);
    vec_t r;
    r.clr = clr; r.chk = chk; r.chkf = chkf; r.ra = ra; r.rb = rb; r.rd = rd;
    r.ua = ua; r.ub = ub; r.ud = ud; r.we = we; r.ld = ld; r.br = br;
    r.fa = fa; r.fb = fb; r.fd = fd; r.pc = pc; r.nop = nop; r.fclr = fclr;
    r.sc = sc; r.fc = fc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit clr, input bit [3:0] ra, input bit [3:0] rb, input bit [3:0] rd,
                       input bit ua, input bit ub, input bit ud, input bit we, input bit ld,
                       input bit br);
    Clr = clr;
    bus.ID_RA = ra; bus.ID_RB = rb; bus.ID_RD = rd;
    bus.use_RA = ua; bus.use_RB = ub; bus.use_RD = ud;
    bus.ID_RF_enable = we; bus.ID_load_instr = ld; bus.branch_taken = br;
  endtask

  // Reference: an operand is forwarded from the youngest in-flight writer of that register,
  // except that a load still in EX has no data yet.
  function automatic bit [1:0] m_fwd(bit u, bit [3:0] s);
    if (!u || s == 4'hF) return 2'b00;
    for (int k = 0; k < 3; k++)
      if (pipe[k].we && pipe[k].rd == s && !(k == 0 && pipe[k].ld)) return 2'(k + 1);
    return 2'b00;
  endfunction

  function automatic bit m_hit(bit u, bit [3:0] s);
    return u && s != 4'hF && pipe[0].we && pipe[0].ld && pipe[0].rd == s;
  endfunction

  initial begin
    inst_t bub;
    bub = '{rd: 4'h0, we: 1'b0, ld: 1'b0};
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //          clr chk chkf ra  rb  rd  ua ub ud we ld br fa fb fd pc nop fclr sc fc
    tbl[0]  = v(1, 0, 0,  3,  0,  3,  1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[1]  = v(1, 1, 1,  3,  0,  3,  1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[2]  = v(0, 1, 1,  3,  0,  3,  1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[3]  = v(0, 1, 1,  3,  0,  0,  1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    tbl[4]  = v(0, 1, 1,  3,  0,  0,  1, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0);
    tbl[5]  = v(0, 1, 1,  3,  0,  0,  1, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    tbl[6]  = v(0, 1, 1,  3,  0,  0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[7]  = v(0, 1, 1,  0,  0,  5,  0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[8]  = v(0, 1, 1,  0,  0,  5,  0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[9]  = v(0, 1, 1,  0,  0,  5,  0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[10] = v(0, 1, 1,  0,  5,  0,  0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    tbl[11] = v(0, 1, 1,  0,  5,  0,  0, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0);
    tbl[12] = v(0, 1, 1,  0,  0,  2,  0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[13] = v(0, 1, 0,  0,  0,  2,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[14] = v(0, 1, 1,  0,  0,  2,  0, 0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0);
    tbl[15] = v(0, 1, 1,  0,  0, 15,  0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    tbl[16] = v(0, 1, 1, 15,  0,  0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    tbl[17] = v(0, 1, 1,  0,  0,  4,  0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    tbl[18] = v(0, 1, 1,  0,  4,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    tbl[19] = v(0, 1, 1,  0,  0,  6,  0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    tbl[20] = v(0, 1, 0,  6,  0,  0,  1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[21] = v(0, 1, 1,  6,  0,  0,  1, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0, 1, 2, 0);
    tbl[22] = v(0, 1, 1,  0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 1);

    foreach (tbl[i]) begin
      @(negedge Clk);
      drive(tbl[i].clr, tbl[i].ra, tbl[i].rb, tbl[i].rd, tbl[i].ua, tbl[i].ub, tbl[i].ud,
            tbl[i].we, tbl[i].ld, tbl[i].br);
      #1;
      if (tbl[i].chk) begin
        if (tbl[i].chkf) begin
          chk($sformatf("vec%0d fwd_A", i), 32'(bus.fwd_A), 32'(tbl[i].fa));
          chk($sformatf("vec%0d fwd_B", i), 32'(bus.fwd_B), 32'(tbl[i].fb));
          chk($sformatf("vec%0d fwd_D", i), 32'(bus.fwd_D), 32'(tbl[i].fd));
        end
        chk($sformatf("vec%0d PC_LE", i), 32'(bus.PC_LE), 32'(tbl[i].pc));
        chk($sformatf("vec%0d IF_ID_LE", i), 32'(bus.IF_ID_LE), 32'(tbl[i].pc));
        chk($sformatf("vec%0d NOP_sel", i), 32'(bus.NOP_sel), 32'(tbl[i].nop));
        chk($sformatf("vec%0d IF_ID_Clr", i), 32'(bus.IF_ID_Clr), 32'(tbl[i].fclr));
        chk($sformatf("vec%0d stall_count", i), 32'(bus.stall_count), 32'(tbl[i].sc));
        chk($sformatf("vec%0d flush_count", i), 32'(bus.flush_count), 32'(tbl[i].fc));
      end
    end

    // Flush counter saturation: flush_count is 1 here; flush on every edge.
    @(negedge Clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (MAXC - 2) @(posedge Clk);
    @(negedge Clk);
    chk("flush_count below max", 32'(bus.flush_count), 32'(MAXC - 1));
    chk("flush no stall PC_LE", 32'(bus.PC_LE), 32'd1);
    chk("flush IF_ID_Clr", 32'(bus.IF_ID_Clr), 32'd1);
    repeat (6) @(posedge Clk);
    @(negedge Clk);
    chk("flush_count saturated", 32'(bus.flush_count), 32'(MAXC));

    // Clear mid-operation: a pending load-use hazard and both counters vanish.
    drive(0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
    @(negedge Clk);
    drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("pre-clear stall", 32'(bus.NOP_sel), 32'd1);
    @(negedge Clk);
    drive(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("post-clear no stall", 32'(bus.PC_LE), 32'd1);
    chk("post-clear fwd_A", 32'(bus.fwd_A), 32'd0);
    chk("post-clear stall_count", 32'(bus.stall_count), 32'd0);
    chk("post-clear flush_count", 32'(bus.flush_count), 32'd0);

    // Randomized traffic against the queue model, starting from a clear.
    @(negedge Clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk);
    pipe = '{bub, bub, bub};
    m_sc = 0;
    m_fc = 0;
    for (int n = 0; n < 3000; n++) begin
      bit [3:0] s[3];
      bit       u[3];
      bit       clr, we, ld, br, st, hit[3];
      bit [1:0] act[3];
      @(negedge Clk);
      for (int j = 0; j < 3; j++) begin
        s[j] = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 5));
        u[j] = 1'($urandom_range(0, 1));
      end
      clr = ($urandom_range(0, 63) == 0);
      we  = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 2) == 0);
      br  = ($urandom_range(0, 3) == 0);
      drive(clr, s[0], s[1], s[2], u[0], u[1], u[2], we, ld, br);
      #1;
      st = 0;
      for (int j = 0; j < 3; j++) begin
        hit[j] = m_hit(u[j], s[j]);
        st |= hit[j];
      end
      act = '{bus.fwd_A, bus.fwd_B, bus.fwd_D};
      for (int j = 0; j < 3; j++)
        if (!hit[j]) chk($sformatf("rnd%0d fwd%0d", n, j), 32'(act[j]), 32'(m_fwd(u[j], s[j])));
      chk($sformatf("rnd%0d PC_LE", n), 32'(bus.PC_LE), 32'(!st));
      chk($sformatf("rnd%0d IF_ID_LE", n), 32'(bus.IF_ID_LE), 32'(!st));
      chk($sformatf("rnd%0d NOP_sel", n), 32'(bus.NOP_sel), 32'(st));
      chk($sformatf("rnd%0d IF_ID_Clr", n), 32'(bus.IF_ID_Clr), 32'(br && !st));
      chk($sformatf("rnd%0d stall_count", n), 32'(bus.stall_count), 32'(m_sc));
      chk($sformatf("rnd%0d flush_count", n), 32'(bus.flush_count), 32'(m_fc));
      @(posedge Clk);
      if (clr) begin
        pipe = '{bub, bub, bub};
        m_sc = 0;
        m_fc = 0;
      end else begin
        inst_t ni;
        ni = st ? bub : '{rd: s[2], we: we, ld: ld};
        pipe.push_front(ni);
        void'(pipe.pop_back());
        if (st && m_sc < MAXC) m_sc++;
        if (br && !st && m_fc < MAXC) m_fc++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
